sap_controller: RTL

SAP_CONTROLLER -- requirements
Module: sap_controller

---
 rtl/sap_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sap_controller.sv
// -----------------------------------------------------------------------------
// sap_controller
//   Hardwired control unit for a SAP-1 style computer. A six-state one-hot
//   ring counter (T1..T6) sequences fetch (T1-T3) and execute (T4-T6); the
//   control word is a purely combinational decode of the current T-state and
//   the instruction register's upper nibble, so it applies in the same cycle.
//
// Ports
//   clk        in   1   system clock, rising-edge
//   reset      in   1   synchronous, active-high; aborts any instruction
//   run        in   1   sequencing enable; 0 stalls and blanks the control word
//   opcode     in   4   instruction register upper nibble (valid from T4)
//   cw_bus     out 14   control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo,Hlt,Clr}
//   t_state    out  6   one-hot ring counter, bit0=T1 .. bit5=T6
//   halted     out  1   set once HLT executes; cleared only by reset
//   instr_done out  1   last cycle (T6) of an instruction that is advancing
// -----------------------------------------------------------------------------
module sap_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [13:0] cw_bus,
  output logic [5:0]  t_state,
  output logic        halted,
  output logic        instr_done
);

  // Control word bit positions
  localparam int unsigned BitCp  = 13;
  localparam int unsigned BitEp  = 12;
  localparam int unsigned BitLm  = 11;
  localparam int unsigned BitCe  = 10;
  localparam int unsigned BitLi  = 9;
  localparam int unsigned BitEi  = 8;
  localparam int unsigned BitLa  = 7;
  localparam int unsigned BitEa  = 6;
  localparam int unsigned BitSu  = 5;
  localparam int unsigned BitEu  = 4;
  localparam int unsigned BitLb  = 3;
  localparam int unsigned BitLo  = 2;
  localparam int unsigned BitHlt = 1;
  localparam int unsigned BitClr = 0;

  // One-hot T-state encodings
  localparam logic [5:0] StT1 = 6'b000001;
  localparam logic [5:0] StT2 = 6'b000010;
  localparam logic [5:0] StT3 = 6'b000100;
  localparam logic [5:0] StT4 = 6'b001000;
  localparam logic [5:0] StT5 = 6'b010000;
  localparam logic [5:0] StT6 = 6'b100000;

  // Opcodes
  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  // Common control words
  localparam logic [13:0] CwNone  = 14'h0000;
  localparam logic [13:0] CwClr   = 14'h0001;
  localparam logic [13:0] CwHlt   = 14'h0002;
  localparam logic [13:0] CwFetch1 = (14'h1 << BitEp) | (14'h1 << BitLm);
  localparam logic [13:0] CwFetch2 = (14'h1 << BitCp);
  localparam logic [13:0] CwFetch3 = (14'h1 << BitCe) | (14'h1 << BitLi);
  localparam logic [13:0] CwAddrLd = (14'h1 << BitEi) | (14'h1 << BitLm);
  localparam logic [13:0] CwMemToA = (14'h1 << BitCe) | (14'h1 << BitLa);
  localparam logic [13:0] CwMemToB = (14'h1 << BitCe) | (14'h1 << BitLb);
  localparam logic [13:0] CwAluAdd = (14'h1 << BitEu) | (14'h1 << BitLa);
  localparam logic [13:0] CwAluSub = (14'h1 << BitSu) | (14'h1 << BitEu) | (14'h1 << BitLa);
  localparam logic [13:0] CwAToOut = (14'h1 << BitEa) | (14'h1 << BitLo);

  logic [5:0]  r_t_state;
  logic        r_halted;
  logic [5:0]  w_t_state_d;
  logic        w_halted_d;
  logic        w_onehot;
  logic [13:0] w_cw;
  logic [13:0] w_exec_cw;

  // Exactly one bit set: non-zero and no second bit.
  assign w_onehot = (r_t_state != 6'b0) && ((r_t_state & (r_t_state - 6'd1)) == 6'b0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t_state <= StT1;
      r_halted  <= 1'b0;
    end else begin
      r_t_state <= w_t_state_d;
      r_halted  <= w_halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_t_state_d = r_t_state;
    w_halted_d  = r_halted;
    if (!w_onehot) begin
      // Corrupted ring: restart at T1 regardless of run/halt.
      w_t_state_d = StT1;
    end else if (r_halted) begin
      w_t_state_d = r_t_state;
    end else if (run) begin
      if ((r_t_state == StT4) && (opcode == OpHlt)) begin
        // HLT parks the ring at T4.
        w_halted_d  = 1'b1;
        w_t_state_d = r_t_state;
      end else begin
        w_t_state_d = {r_t_state[4:0], r_t_state[5]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Execute-phase decode (T4..T6); opcode is used live, never latched.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_exec_cw = CwNone;
    unique case (opcode)
      OpLda: begin
        if (r_t_state == StT4) w_exec_cw = CwAddrLd;
        if (r_t_state == StT5) w_exec_cw = CwMemToA;
      end
      OpAdd: begin
        if (r_t_state == StT4) w_exec_cw = CwAddrLd;
        if (r_t_state == StT5) w_exec_cw = CwMemToB;
        if (r_t_state == StT6) w_exec_cw = CwAluAdd;
      end
      OpSub: begin
        if (r_t_state == StT4) w_exec_cw = CwAddrLd;
        if (r_t_state == StT5) w_exec_cw = CwMemToB;
        if (r_t_state == StT6) w_exec_cw = CwAluSub;
      end
      OpOut: begin
        if (r_t_state == StT4) w_exec_cw = CwAToOut;
      end
      OpHlt: begin
        if (r_t_state == StT4) w_exec_cw = CwHlt;
      end
      default: w_exec_cw = CwNone; // NOP
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: reset > halted > stall > T-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cw = CwNone;
    if (reset) begin
      w_cw = CwClr;
    end else if (r_halted) begin
      w_cw = CwHlt;
    end else if (!run) begin
      w_cw = CwNone;
    end else begin
      case (r_t_state)
        StT1:    w_cw = CwFetch1;
        StT2:    w_cw = CwFetch2;
        StT3:    w_cw = CwFetch3;
        StT4,
        StT5,
        StT6:    w_cw = w_exec_cw;
        default: w_cw = CwNone; // illegal ring value drives nothing
      endcase
    end
  end

  assign cw_bus     = w_cw;
  assign t_state    = r_t_state;
  assign halted     = r_halted;
  assign instr_done = !reset && run && !r_halted && (r_t_state == StT6);

endmodule
